// File: rtl/vertex_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vertex_sched_if : batch control, vertex-memory and datapath signal bundle |
// | Optional define VERTEX_SCHED_PERF_EN adds stall_cycles / batch_cycles.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface vertex_sched_if;
  logic              start;
  logic [15:0]       base_addr;
  logic [15:0]       tri_count;
  logic              mat_we;
  logic [3:0]        mat_idx;
  logic [31:0]       mat_wdata;
  logic [15:0][31:0] mat;
  logic              rd_en;
  logic [15:0]       rd_addr;
  logic [31:0]       rd_data;
  logic [14:0][31:0] v_in;
  logic [23:0]       color1;
  logic [23:0]       color2;
  logic [23:0]       color3;
  logic              vc_valid;
  logic              vc_done;
  logic              vc_stall;
  logic              busy;
  logic              done;
`ifdef VERTEX_SCHED_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       batch_cycles;

  modport master (
    input  start, base_addr, tri_count, mat_we, mat_idx, mat_wdata, rd_data, vc_stall,
    output mat, rd_en, rd_addr, v_in, color1, color2, color3,
           vc_valid, vc_done, busy, done, stall_cycles, batch_cycles
  );
  modport slave (
    output start, base_addr, tri_count, mat_we, mat_idx, mat_wdata, rd_data, vc_stall,
    input  mat, rd_en, rd_addr, v_in, color1, color2, color3,
           vc_valid, vc_done, busy, done, stall_cycles, batch_cycles
  );
`else
  modport master (
    input  start, base_addr, tri_count, mat_we, mat_idx, mat_wdata, rd_data, vc_stall,
    output mat, rd_en, rd_addr, v_in, color1, color2, color3,
           vc_valid, vc_done, busy, done
  );
  modport slave (
    output start, base_addr, tri_count, mat_we, mat_idx, mat_wdata, rd_data, vc_stall,
    input  mat, rd_en, rd_addr, v_in, color1, color2, color3,
           vc_valid, vc_done, busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/vertex_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vertex_sched : fetches 15-word triangle records and issues them in order  |
// | Optional define VERTEX_SCHED_PERF_EN adds stall/batch cycle counters.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vertex_sched (
  input  logic           clk,
  input  logic           rst_n,
  vertex_sched_if.master bus
);
  localparam logic [3:0]  C_LAST_WORD = 4'd14;
  localparam logic [4:0]  C_NUM_WORDS = 5'd15;
  localparam logic [31:0] C_ONE       = 32'h0001_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_base;
  logic [15:0]       r_count;
  logic [15:0]       r_tri_idx;
  logic [4:0]        r_req_cnt;
  logic              r_rd_en;
  logic [15:0]       r_rd_addr;
  logic [3:0]        r_rd_k;
  logic              r_pend;
  logic [3:0]        r_pend_k;
  logic [15:0][31:0] r_mat;
  logic [14:0][31:0] r_v_in;
  logic              r_done;
  logic              w_start_ok;
  logic              w_xfer;
  logic              w_last;
  logic              w_cap_last;
  logic              w_issue_req;

  assign w_last      = (r_tri_idx == r_count - 16'd1);
  assign w_cap_last  = r_pend && (r_pend_k == C_LAST_WORD);
  assign w_issue_req = (r_state == S_FETCH) && (r_req_cnt != C_NUM_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_xfer     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_ok = 1'b1;
          w_next     = (bus.tri_count == 16'd0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_cap_last) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.vc_stall) begin
          w_xfer = 1'b1;
          w_next = w_last ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_count   <= '0;
      r_tri_idx <= '0;
      r_req_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      if (w_start_ok) begin
        r_base    <= bus.base_addr;
        r_count   <= bus.tri_count;
        r_tri_idx <= '0;
        r_req_cnt <= '0;
      end else if (w_xfer && !w_last) begin
        r_tri_idx <= r_tri_idx + 16'd1;
        r_req_cnt <= '0;
      end else if (w_issue_req) begin
        r_req_cnt <= r_req_cnt + 5'd1;
      end
    end
  end

  // Read data returns one cycle after the request; r_pend/r_pend_k track it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_k    <= '0;
      r_pend    <= 1'b0;
      r_pend_k  <= '0;
      r_v_in    <= '0;
    end else begin
      r_rd_en  <= w_issue_req;
      r_pend   <= r_rd_en;
      r_pend_k <= r_rd_k;
      if (w_issue_req) begin
        r_rd_addr <= r_base + {r_tri_idx[11:0], 4'b0000} + {12'd0, r_req_cnt[3:0]};
        r_rd_k    <= r_req_cnt[3:0];
      end
      if (r_pend) begin
        r_v_in[r_pend_k] <= bus.rd_data;
      end
    end
  end

  // Diagonal words (0, 5, 10, 15) reset to 1.0 in 16.16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_mat[i] <= ((i % 5) == 0) ? C_ONE : 32'd0;
      end
    end else if (bus.mat_we && (r_state == S_IDLE)) begin
      r_mat[bus.mat_idx] <= bus.mat_wdata;
    end
  end

`ifdef VERTEX_SCHED_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_batch_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_batch_cycles <= '0;
    end else if (w_start_ok) begin
      r_stall_cycles <= '0;
      r_batch_cycles <= '0;
    end else begin
      if (r_state != S_IDLE) begin
        r_batch_cycles <= r_batch_cycles + 32'd1;
      end
      if ((r_state == S_ISSUE) && bus.vc_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.batch_cycles = r_batch_cycles;
`endif

  assign bus.mat      = r_mat;
  assign bus.rd_en    = r_rd_en;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.v_in     = r_v_in;
  assign bus.color1   = r_v_in[3][23:0];
  assign bus.color2   = r_v_in[7][23:0];
  assign bus.color3   = r_v_in[11][23:0];
  assign bus.vc_valid = (r_state == S_ISSUE);
  assign bus.vc_done  = (r_state == S_ISSUE) && w_last;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
endmodule
`default_nettype wire
